// File: rtl/load_store_unit.sv
// load_store_unit: single-transaction memory stage between the ALU and writeback.
// Build macro MISALIGN_TRAP_EN: misaligned accesses are reported instead of being force-aligned.
module load_store_unit #(
  parameter int MEM_RD_LATENCY = 1  // legal 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [3:0] LAT = 4'(MEM_RD_LATENCY);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        misalign_q, misalign_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        req_trap;
  logic [1:0]  lane_off;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [15:0] load_shift;
  logic [31:0] load_data;

  // Byte offset after forcing halves/words to natural alignment; funct3[1:0]=2'b11 acts as W.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  assign req_trap = misaligned(req_funct3, req_addr[1:0]);
`else
  assign req_trap = 1'b0;
`endif

  assign lane_off = align_off(funct3_q, addr_q[1:0]);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    lane_mask = 4'b1111;
    lane_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << lane_off;
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011 << lane_off;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign load_shift = 16'(mem_rdata >> {lane_off, 3'b000});

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b100:  load_data = {24'h0, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b101:  load_data = {16'h0, load_shift[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    misalign_d  = misalign_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          misalign_d = req_trap;
          if (req_trap) begin
            rsp_rdata_d = 32'h0;
            state_d     = S_RESP;
          end else if (req_is_store) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        rsp_rdata_d = 32'h0;
        state_d     = S_RESP;
      end
      S_READ: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The count hits zero in the cycle mem_rdata is valid; capture it on that edge.
        if (cnt_q <= 4'd1) begin
          cnt_d       = 4'd0;
          rsp_rdata_d = load_data;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous -- rst_n is only looked at on the rising clock edge.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      misalign_q  <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      misalign_q  <= misalign_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign mem_rd_en    = (state_q == S_READ);
  assign mem_wr_en    = (state_q == S_WRITE) && is_store_q;
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_misalign = rsp_valid && misalign_q;
  assign rsp_rdata    = rsp_rdata_q;

  // Memory-side buses are quiet (zero) whenever no strobe is active.
  assign mem_addr  = (mem_rd_en || mem_wr_en) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wmask = mem_wr_en ? lane_mask : 4'b0000;
  assign mem_wdata = mem_wr_en ? lane_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a byte-array reference model.
module tb_load_store_unit;

  localparam int LAT = 3;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.MEM_RD_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign)
  );

  always #5 clk = ~clk;

  // Memory device: rdata valid for exactly one cycle, LAT cycles after the read strobe; noise otherwise.
  logic [31:0] dev_mem [0:1023];
  bit          mem_init = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) dev_mem[i] <= 32'h0;
      dev_mem[32'h100 >> 2] <= 32'h8899_AABB;
      mem_init <= 1'b1;
    end else begin
      mem_rdata <= $urandom();
      if (pend_cnt == 1) mem_rdata <= dev_mem[pend_addr[11:2]];
      if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
      if (mem_rd_en) begin
        if (LAT == 1) mem_rdata <= dev_mem[mem_addr[11:2]];
        else begin
          pend_cnt  <= LAT - 1;
          pend_addr <= mem_addr;
        end
      end
      if (mem_wr_en)
        for (int i = 0; i < 4; i++)
          if (mem_wmask[i]) dev_mem[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // Reference memory, updated only from the model's view of each store.
  logic [31:0] ref_mem [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] e_rd, output logic e_mis,
                                output logic [3:0] e_mask, output logic [31:0] e_wd);
    int size, off;
    longint span, data, rep, val;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(a % 32'd4);
    span = longint'(1) << (8 * size);
    e_rd = 32'h0; e_mis = 1'b0; e_mask = 4'h0; e_wd = 32'h0;
    if ((off % size) != 0 && TRAP) begin
      e_mis = 1'b1;
      return;
    end
    off = off - (off % size);
    if (st) begin
      data = longint'(wd) % span;
      rep  = 0;
      for (int i = 0; i < 4 / size; i++) rep += data << (8 * size * i);
      e_mask = 4'(((1 << size) - 1) << off);
      e_wd   = 32'(rep);
    end else begin
      val = (longint'(ref_mem[a[11:2]]) >> (8 * off)) % span;
      if (!f3[2] && size < 4 && val >= (span >> 1)) val -= span;
      e_rd = 32'(val);
    end
  endfunction

  task automatic do_txn(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] e_rd, input logic e_mis,
                        input logic [3:0] e_mask, input logic [31:0] e_wd);
    int rsp_cyc = 0, rd_n = 0, wr_n = 0, strobe_cyc = 0, bad_busy = 0, bad_idle = 0;
    int exp_cyc;
    logic exp_rd, exp_wr;
    logic [31:0] got_rd = 32'h0, s_addr = 32'h0, s_wd = 32'h0;
    logic [3:0]  s_mask = 4'h0;
    logic        got_mis = 1'b0;
    exp_rd  = !st && !e_mis;
    exp_wr  = st && !e_mis;
    exp_cyc = e_mis ? 1 : (st ? 2 : 2 + LAT);
    @(negedge clk);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int c = 1; c <= 40 && rsp_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (req_ready) bad_busy++;
      if (mem_rd_en) rd_n++;
      if (mem_wr_en) wr_n++;
      if (mem_rd_en || mem_wr_en) begin
        strobe_cyc = c; s_addr = mem_addr; s_mask = mem_wmask; s_wd = mem_wdata;
      end else if (mem_addr !== 32'h0 || mem_wmask !== 4'h0 || mem_wdata !== 32'h0) bad_idle++;
      if (rsp_valid) begin
        rsp_cyc = c; got_rd = rsp_rdata; got_mis = rsp_misalign;
      end
    end
    check({tag, " rsp cycle"}, rsp_cyc, exp_cyc);
    check({tag, " rsp_rdata"}, got_rd, e_rd);
    check({tag, " rsp_misalign"}, 32'(got_mis), 32'(e_mis));
    check({tag, " rd strobes"}, rd_n, 32'(exp_rd));
    check({tag, " wr strobes"}, wr_n, 32'(exp_wr));
    check({tag, " busy ready"}, bad_busy, 0);
    check({tag, " idle buses"}, bad_idle, 0);
    if (rd_n + wr_n > 0) begin
      check({tag, " strobe cycle"}, strobe_cyc, 1);
      check({tag, " mem_addr"}, s_addr, a & 32'hFFFF_FFFC);
      check({tag, " mem_wmask"}, 32'(s_mask), 32'(exp_wr ? e_mask : 4'h0));
      check({tag, " mem_wdata"}, s_wd, exp_wr ? e_wd : 32'h0);
    end
    @(negedge clk);
    check({tag, " rsp pulse end"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready after"}, 32'(req_ready), 32'd1);
    check({tag, " rdata held"}, rsp_rdata, got_rd);
    if (exp_wr)
      for (int i = 0; i < 4; i++)
        if (e_mask[i]) ref_mem[a[11:2]][8*i +: 8] = e_wd[8*i +: 8];
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic        e_mis;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t        vecs[$];
  logic [2:0]  f3_opts [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};

  initial begin
    int cnt_a, cnt_b, cnt_c, rsp_c;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[32'h100 >> 2] = 32'h8899_AABB;

    vecs.push_back('{1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFF_FFAA, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b101, 32'h102, 32'h0, 32'h0000_8899, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 32'h100, 32'h0, 32'h8899_AABB, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0088, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF_8899, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFF_AABB, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 3'b000, 32'h203, 32'h1234_5678, 32'h0, 1'b0, 4'b1000, 32'h7878_7878});
    vecs.push_back('{1'b0, 3'b010, 32'h200, 32'h0, 32'h7800_0000, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 32'h206, 32'hCAFE_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF});
    vecs.push_back('{1'b0, 3'b010, 32'h204, 32'h0, 32'hBEEF_0000, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 32'h102, 32'h0, TRAP ? 32'h0 : 32'h8899_AABB, TRAP, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b001, 32'h101, 32'h0, TRAP ? 32'h0 : 32'hFFFF_AABB, TRAP, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 3'b010, 32'h209, 32'h1122_3344, 32'h0, TRAP,
                     TRAP ? 4'h0 : 4'hF, TRAP ? 32'h0 : 32'h1122_3344});
    vecs.push_back('{1'b0, 3'b010, 32'h208, 32'h0, TRAP ? 32'h0 : 32'h1122_3344, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b011, 32'h100, 32'h0, 32'h8899_AABB, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 3'b100, 32'h20C, 32'h0000_00A5, 32'h0, 1'b0, 4'b0001, 32'hA5A5_A5A5});
    vecs.push_back('{1'b0, 3'b100, 32'h20C, 32'h0, 32'h0000_00A5, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 32'h20C, 32'h0, 32'hFFFF_FFA5, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b1, 3'b101, 32'h20E, 32'h0000_7F01, 32'h0, 1'b0, 4'b1100, 32'h7F01_7F01});
    vecs.push_back('{1'b0, 3'b001, 32'h20E, 32'h0, 32'h0000_7F01, 1'b0, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 32'h20C, 32'h0, 32'h7F01_00A5, 1'b0, 4'h0, 32'h0});

    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset strobes", {30'h0, mem_rd_en, mem_wr_en}, 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wmask", 32'(mem_wmask), 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_misalign", 32'(rsp_misalign), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].e_rdata, vecs[i].e_mis, vecs[i].e_mask, vecs[i].e_wdata);

    // req_valid held through a load: one accept, busy cycles 1..5, next accept at the cycle-6 edge.
    @(negedge clk);
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
    @(posedge clk);
    cnt_a = 0; cnt_b = 0; rsp_c = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (req_ready) cnt_a++;
      if (mem_rd_en) cnt_b++;
      if (rsp_valid) rsp_c = c;
    end
    check("hold busy ready", cnt_a, 0);
    check("hold rd strobes", cnt_b, 1);
    check("hold rsp cycle", rsp_c, 2 + LAT);
    @(negedge clk);
    check("hold ready cycle6", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("hold second accept", 32'(mem_rd_en), 32'd1);
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
    check("hold second rsp", 32'(rsp_valid), 32'd1);
    check("hold second rdata", rsp_rdata, 32'h8899_AABB);
    @(negedge clk);

    // Reset during WAIT aborts the load; the late read data must not surface.
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h208; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort rsp_rdata", rsp_rdata, 32'h0);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) cnt_a++;
      if (mem_rd_en || mem_wr_en) cnt_b++;
      if (!req_ready) cnt_c++;
    end
    check("abort no rsp", cnt_a, 0);
    check("abort no strobe", cnt_b, 0);
    check("abort stays idle", cnt_c, 0);
    check("abort rdata still 0", rsp_rdata, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic        st, e_mis;
      logic [2:0]  f3;
      logic [3:0]  e_mask;
      logic [31:0] a, wd, e_rd, e_wd;
      st = 1'($urandom_range(0, 1));
      f3 = f3_opts[$urandom_range(0, 6)];
      a  = ($urandom() & 32'hFFFF_F000) | (32'h300 + 32'($urandom_range(0, 63)));
      wd = $urandom();
      model(st, f3, a, wd, e_rd, e_mis, e_mask, e_wd);
      do_txn($sformatf("rnd%0d", i), st, f3, a, wd, e_rd, e_mis, e_mask, e_wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
